// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } cnt_mode_e;

  // Index width for a count of items, never narrower than one bit.
  function automatic int ch_idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic logic [63:0] pwm_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and period counter; produces the boundary strobe and period_start.
// PWM_CENTER_ALIGN_EN adds the center input and triangle counting.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic             center,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             boundary,
  output logic             period_start
);

  localparam int             PW         = ch_idx_w(PRESCALE);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_TOP  = WIDTH'(pwm_max(WIDTH) - 64'd1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             period_start_q, period_start_d;
  logic             tick;

  assign tick = (presc_q == PRESC_LAST);

`ifdef PWM_CENTER_ALIGN_EN
  cnt_mode_e mode_q, mode_d;
  logic      dir_q, dir_d;   // 1 = counting down

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    boundary = 1'b0;
    if (tick) begin
      if (mode_q == MODE_CENTER) begin
        if (dir_q) begin
          if (cnt_q == WIDTH'(1)) begin
            boundary = 1'b1;
            cnt_d    = '0;
            dir_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else if (cnt_q == CNT_TOP) begin
          dir_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (cnt_q == CNT_TOP) begin
        boundary = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Mode is only sampled at a boundary so a period never changes shape midway.
      if (boundary) mode_d = center ? MODE_CENTER : MODE_EDGE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_EDGE;
      dir_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
    end
  end
`else
  always_comb begin
    cnt_d    = cnt_q;
    boundary = tick && (cnt_q == CNT_TOP);
    if (tick) cnt_d = boundary ? '0 : cnt_q + 1'b1;
  end
`endif

  always_comb begin
    presc_d        = tick ? '0 : presc_q + 1'b1;
    period_start_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign cnt          = cnt_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM with duty values double-buffered and loaded at period boundaries.
// PWM_CENTER_ALIGN_EN adds the center input for triangle (center-aligned) counting.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ch_idx_w(CHANNELS)-1:0] wr_ch,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [CHANNELS-1:0]           ch_en,
  input  logic [CHANNELS-1:0]           pol,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                          center,
`endif
  output logic [CHANNELS-1:0]           pwm_out,
  output logic                          period_start
);

  logic [WIDTH-1:0] cnt;
  logic             boundary;
  logic             wr_ok;

  pwm_timebase #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
`ifdef PWM_CENTER_ALIGN_EN
    .center       (center),
`endif
    .cnt          (cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign wr_ok = wr_en && (32'(wr_ch) < 32'(CHANNELS));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    // The boundary load takes pending_q, so a write on the boundary cycle waits a period.
    always_comb begin
      pending_d = pending_q;
      if (wr_ok && (32'(wr_ch) == 32'(i))) pending_d = wr_data;
      active_d = boundary ? pending_q : active_q;
      pwm_d    = ch_en[i] ? ((cnt < active_q) ^ pol[i]) : pol[i];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pending_q <= '0;
        active_q  <= '0;
        pwm_q     <= 1'b0;
      end else begin
        pending_q <= pending_d;
        active_q  <= active_d;
        pwm_q     <= pwm_d;
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench: randomized duties against a cycle reference model plus per-period duty counts.
module tb_pwm_multi_channel;

  localparam int W   = 5;
  localparam int CH  = 3;
  localparam int P   = 3;
  localparam int MAX = (1 << W) - 1;
  localparam int PER = MAX * P;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] pol;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  int total = 0;
  int bad   = 0;

  int            e;
  logic [W-1:0]  m_pend [CH];
  logic [W-1:0]  m_act  [CH];
  logic [CH-1:0] m_pwm;
  logic          m_ps;

  int hi [CH];
  int ps_cnt;
  int d0, d1, d2;

  pwm_multi_channel #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .PRESCALE (P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_data      (wr_data),
    .ch_en        (ch_en),
    .pol          (pol),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: counter position follows from the number of edges since reset.
  function automatic bit next_is_boundary();
    return ((e % P) == P - 1) && (((e / P) % MAX) == MAX - 1);
  endfunction

  task automatic cycle();
    int cb;
    bit bnd;
    @(posedge clk);
    if (rst) begin
      e     = 0;
      m_pwm = '0;
      m_ps  = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_pend[i] = '0;
        m_act[i]  = '0;
      end
    end else begin
      cb  = (e / P) % MAX;
      bnd = next_is_boundary();
      for (int i = 0; i < CH; i++)
        m_pwm[i] = ch_en[i] ? ((cb < int'(m_act[i])) ^ pol[i]) : pol[i];
      m_ps = bnd;
      if (bnd) for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
      if (wr_en && (int'(wr_ch) < CH)) m_pend[wr_ch] = wr_data;
      e++;
    end
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("period_start", 32'(period_start), 32'(m_ps));
  endtask

  task automatic write(input int ch, input int data);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_data = W'(data);
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps();
    bit found = 1'b0;
    for (int k = 0; k < PER + 5 && !found; k++) begin
      cycle();
      if (period_start) found = 1'b1;
    end
    chk("wait_period_start", 32'(found), 32'd1);
  endtask

  // Counts one period of outputs, starting from a period_start sample.
  task automatic measure_now(input bit do_mid, input int mid_ch, input int mid_data);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    ps_cnt = 0;
    for (int k = 1; k <= PER; k++) begin
      if (do_mid && k == PER / 2) begin
        wr_en = 1'b1; wr_ch = 2'(mid_ch); wr_data = W'(mid_data);
      end else begin
        wr_en = 1'b0;
      end
      cycle();
      for (int i = 0; i < CH; i++) if (pwm_out[i]) hi[i]++;
      if (period_start) ps_cnt++;
    end
    wr_en = 1'b0;
  endtask

  task automatic chk_period(input string tag, input int e0, input int e1, input int e2);
    chk({tag, "_ch0_high"}, 32'(hi[0]), 32'(e0));
    chk({tag, "_ch1_high"}, 32'(hi[1]), 32'(e1));
    chk({tag, "_ch2_high"}, 32'(hi[2]), 32'(e2));
    chk({tag, "_period_starts"}, 32'(ps_cnt), 32'd1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    ch_en = '0; pol = 3'b111;
    e = 0; m_pwm = '0; m_ps = 1'b0;
    for (int i = 0; i < CH; i++) begin m_pend[i] = '0; m_act[i] = '0; end

    repeat (3) cycle();
    chk("reset_pwm_zero", 32'(pwm_out), 32'd0);
    chk("reset_ps_zero", 32'(period_start), 32'd0);
    rst = 1'b0;
    cycle();
    chk("release_inactive_level", 32'(pwm_out), 32'(3'b111));

    // Basic duty and both extremes.
    pol = '0; ch_en = 3'b111;
    d0 = $urandom_range(1, MAX - 1);
    write(0, d0);
    write(1, 0);
    write(2, MAX);
    wait_ps();
    measure_now(1'b0, 0, 0);
    chk_period("basic", d0 * P, 0, PER);
    measure_now(1'b0, 0, 0);
    chk_period("basic2", d0 * P, 0, PER);

    // Inverted full-duty channel is constantly low.
    pol = 3'b100;
    measure_now(1'b0, 0, 0);
    chk_period("pol_full", d0 * P, 0, 0);
    pol = '0;

    // Mid-period write keeps the running period intact.
    do d1 = $urandom_range(1, MAX - 1); while (d1 == d0);
    measure_now(1'b1, 0, d1);
    chk_period("midwrite_old", d0 * P, 0, PER);
    measure_now(1'b0, 0, 0);
    chk_period("midwrite_new", d1 * P, 0, PER);

    // Write landing on the boundary edge applies one period later.
    do d2 = $urandom_range(1, MAX - 1); while (d2 == d1);
    for (int k = 0; k < PER + 2 && !next_is_boundary(); k++) cycle();
    write(0, d2);
    chk("bnd_write_ps", 32'(period_start), 32'd1);
    measure_now(1'b0, 0, 0);
    chk_period("bnd_write_old", d1 * P, 0, PER);
    measure_now(1'b0, 0, 0);
    chk_period("bnd_write_new", d2 * P, 0, PER);

    // Out-of-range channel is ignored.
    write(3, $urandom_range(1, MAX - 1));
    wait_ps();
    measure_now(1'b0, 0, 0);
    chk_period("bad_channel", d2 * P, 0, PER);

    // Random traffic checked every cycle against the model.
    for (int k = 0; k < 400; k++) begin
      wr_en   = 1'($urandom);
      wr_ch   = 2'($urandom);
      wr_data = W'($urandom);
      if ((k % 37) == 0) begin
        ch_en = CH'($urandom);
        pol   = CH'($urandom);
      end
      cycle();
    end
    wr_en = 1'b0;

    // Mid-period reset aborts the period and restarts from zero duty.
    pol = 3'b011; ch_en = 3'b110;
    rst = 1'b1;
    repeat (2) cycle();
    chk("midreset_pwm_zero", 32'(pwm_out), 32'd0);
    rst = 1'b0;
    cycle();
    chk("midreset_release", 32'(pwm_out), 32'(3'b011));
    pol = '0; ch_en = 3'b111;
    for (int k = 0; k < 150; k++) begin
      wr_en   = 1'($urandom);
      wr_ch   = 2'($urandom);
      wr_data = W'($urandom);
      cycle();
    end
    wr_en = 1'b0;
    write(0, d0);
    write(1, MAX);
    write(2, 0);
    wait_ps();
    wait_ps();
    measure_now(1'b0, 0, 0);
    chk_period("after_reset", d0 * P, PER, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
